// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: access size encodings, writeback control bit
// positions and the MEM-stage FSM state type.
package pipe_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_REQ  = 1'b1;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: alignment check, byte enables, store data
// replication and load lane extraction with sign/zero extension.
module mem_lane_align
  import pipe_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata_raw,
  input  logic [31:0] rdata_raw,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = rdata_raw[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    misaligned = 1'b0;
    be         = 4'b0000;
    wdata      = wdata_raw;
    rdata_ext  = rdata_raw;
    case (size)
      SIZE_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{wdata_raw[7:0]}};
        rdata_ext = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      SIZE_H: begin
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{wdata_raw[15:0]}};
        rdata_ext  = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      end
      SIZE_W: begin
        misaligned = |addr_lo;
        be         = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues handshaked loads/stores, stalls upstream while an
// access is outstanding and hands results (or an access error) to MEM_WB.
module mem_access_stage
  import pipe_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  size_in,
  input  logic        unsigned_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  write_dest_in,
  input  logic [1:0]  wb_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [31:0] read_data,
  output logic [31:0] alu_result,
  output logic [4:0]  write_dest,
  output logic [1:0]  wb,
  output logic        mem_err
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_reg;
  logic [7:0]  wait_cnt_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic        we_reg;
  logic [4:0]  dest_reg;
  logic [1:0]  wb_reg;

  logic        in_req, memop, acc_err, clean_memop, timeout;
  logic        al_misaligned;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign in_req      = (state_reg == ST_REQ);
  assign memop       = mem_read_in | mem_write_in;

  // One aligner serves both phases: incoming fields in IDLE for the error
  // check, captured fields in REQ for the bus and the load result.
  mem_lane_align u_align (
    .size        (in_req ? size_reg : size_in),
    .addr_lo     (in_req ? addr_reg[1:0] : alu_result_in[1:0]),
    .is_unsigned (in_req ? unsigned_reg : unsigned_in),
    .wdata_raw   (in_req ? wdata_reg : write_data_in),
    .rdata_raw   (dmem_rdata),
    .misaligned  (al_misaligned),
    .be          (al_be),
    .wdata       (al_wdata),
    .rdata_ext   (al_rdata)
  );

  assign acc_err     = memop & ((mem_read_in & mem_write_in) | (size_in == 2'b11) | al_misaligned);
  assign clean_memop = memop & ~acc_err;
  assign timeout     = in_req & ~dmem_ready & (wait_cnt_reg == WAIT_LAST);

  assign stall_out  = in_req ? (~dmem_ready & ~timeout) : (valid_in & clean_memop);
  assign dmem_req   = in_req;
  assign dmem_we    = in_req & we_reg;
  assign dmem_addr  = in_req ? {addr_reg[31:2], 2'b00} : 32'd0;
  assign dmem_be    = in_req ? al_be : 4'd0;
  assign dmem_wdata = in_req ? al_wdata : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= 8'd0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      size_reg     <= 2'd0;
      unsigned_reg <= 1'b0;
      we_reg       <= 1'b0;
      dest_reg     <= 5'd0;
      wb_reg       <= 2'd0;
      valid_out    <= 1'b0;
      mem_err      <= 1'b0;
      read_data    <= 32'd0;
      alu_result   <= 32'd0;
      write_dest   <= 5'd0;
      wb           <= 2'd0;
    end else begin
      valid_out <= 1'b0;
      mem_err   <= 1'b0;
      if (!in_req) begin
        if (valid_in && clean_memop) begin
          addr_reg     <= alu_result_in;
          wdata_reg    <= write_data_in;
          size_reg     <= size_in;
          unsigned_reg <= unsigned_in;
          we_reg       <= mem_write_in;
          dest_reg     <= write_dest_in;
          wb_reg       <= wb_in;
          wait_cnt_reg <= 8'd0;
          state_reg    <= ST_REQ;
        end else if (valid_in) begin
          valid_out  <= 1'b1;
          mem_err    <= acc_err;
          alu_result <= alu_result_in;
          write_dest <= write_dest_in;
          wb         <= acc_err ? 2'b00 : wb_in;
        end
      end else if (dmem_ready || timeout) begin
        valid_out    <= 1'b1;
        mem_err      <= timeout;
        alu_result   <= addr_reg;
        write_dest   <= dest_reg;
        wb           <= timeout ? 2'b00 : wb_reg;
        wait_cnt_reg <= 8'd0;
        state_reg    <= ST_IDLE;
        if (!timeout) read_data <= we_reg ? 32'd0 : al_rdata;
      end else begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: hand-computed vector table, reset corner cases
// and randomized instructions checked against an arithmetic reference model.
module tb_mem_access_stage;

  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0;
  logic [1:0]  size_in = 2'd0;
  logic        unsigned_in = 1'b0;
  logic [31:0] alu_result_in = 32'd0, write_data_in = 32'd0;
  logic [4:0]  write_dest_in = 5'd0;
  logic [1:0]  wb_in = 2'd0;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        valid_out, mem_err;
  logic [31:0] read_data, alu_result;
  logic [4:0]  write_dest;
  logic [1:0]  wb;

  always #5 clk = ~clk;

  mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .size_in(size_in), .unsigned_in(unsigned_in),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .write_dest_in(write_dest_in), .wb_in(wb_in), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .valid_out(valid_out), .read_data(read_data),
    .alu_result(alu_result), .write_dest(write_dest), .wb(wb), .mem_err(mem_err)
  );

  typedef struct packed {
    logic        rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata;
    logic [4:0]  dest;
    logic [1:0]  wb;
    logic [7:0]  waits;
    logic [31:0] rdata;
  } in_t;

  typedef struct packed {
    logic        is_req, mem_err;
    logic [31:0] daddr;
    logic [3:0]  be;
    logic [31:0] dwdata;
    logic        upd;
    logic [31:0] rd_val;
    logic [1:0]  wb;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_rd = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic in_t mk_in(logic rd, logic wr, logic [1:0] size, logic uns,
                                logic [31:0] addr, logic [31:0] wdata, logic [4:0] dest,
                                logic [1:0] wbv, logic [7:0] waits, logic [31:0] rdata);
    in_t t;
    t.rd = rd; t.wr = wr; t.size = size; t.uns = uns; t.addr = addr;
    t.wdata = wdata; t.dest = dest; t.wb = wbv; t.waits = waits; t.rdata = rdata;
    return t;
  endfunction

  function automatic exp_t mk_exp(logic is_req, logic err, logic [31:0] daddr, logic [3:0] be,
                                  logic [31:0] dwdata, logic upd, logic [31:0] rd_val,
                                  logic [1:0] wbv);
    exp_t t;
    t.is_req = is_req; t.mem_err = err; t.daddr = daddr; t.be = be;
    t.dwdata = dwdata; t.upd = upd; t.rd_val = rd_val; t.wb = wbv;
    return t;
  endfunction

  // Reference model: derives the expected outcome from the access rules with
  // plain arithmetic on the byte address.
  function automatic exp_t model(in_t v);
    exp_t e;
    int unsigned a, v8, v16;
    logic bad, err, tmo;
    logic [31:0] lv;
    a   = v.addr % 4;
    bad = (v.rd && v.wr) || v.size == 2'd3 || (v.size == 2'd1 && a % 2 != 0) ||
          (v.size == 2'd2 && a != 0);
    err = (v.rd || v.wr) && bad;
    e.is_req  = (v.rd || v.wr) && !err;
    tmo       = e.is_req && (int'(v.waits) >= MAX_WAIT);
    e.mem_err = err || tmo;
    e.wb      = e.mem_err ? 2'b00 : v.wb;
    e.daddr   = v.addr - a;
    e.be      = (v.size == 2'd0) ? 4'(1 << a) : (v.size == 2'd1) ? 4'(3 << a) : 4'hF;
    e.dwdata  = (v.size == 2'd0) ? (v.wdata & 32'hFF) * 32'h01010101 :
                (v.size == 2'd1) ? (v.wdata & 32'hFFFF) * 32'h00010001 : v.wdata;
    v8  = (v.rdata >> (8 * a)) & 32'hFF;
    v16 = (v.rdata >> (8 * a)) & 32'hFFFF;
    if (v.size == 2'd0) lv = (!v.uns && v8 >= 128) ? v8 + 32'hFFFFFF00 : v8;
    else if (v.size == 2'd1) lv = (!v.uns && v16 >= 32768) ? v16 + 32'hFFFF0000 : v16;
    else lv = v.rdata;
    e.upd    = e.is_req && !tmo;
    e.rd_val = v.wr ? 32'd0 : lv;
    return e;
  endfunction

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    chk({tag, ".valid_out"}, 32'(valid_out), 32'd0);
    chk({tag, ".mem_err"}, 32'(mem_err), 32'd0);
    chk({tag, ".dmem_req"}, 32'(dmem_req), 32'd0);
  endtask

  // Drives one instruction from accept to result; starts and ends at posedge+1.
  task automatic run_instr(input vec_t v, input int id);
    logic rdy, last, done;
    valid_in = 1'b1; mem_read_in = v.i.rd; mem_write_in = v.i.wr;
    size_in = v.i.size; unsigned_in = v.i.uns; alu_result_in = v.i.addr;
    write_data_in = v.i.wdata; write_dest_in = v.i.dest; wb_in = v.i.wb;
    dmem_ready = 1'($urandom % 2); dmem_rdata = $urandom;
    #1;
    chk("accept.stall_out", 32'(stall_out), 32'(v.e.is_req));
    chk("accept.dmem_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    if (v.e.is_req) begin
      done = 1'b0;
      for (int k = 0; k < MAX_WAIT && !done; k++) begin
        rdy  = (k == int'(v.i.waits));
        last = (k == MAX_WAIT - 1);
        dmem_ready = rdy;
        dmem_rdata = rdy ? v.i.rdata : $urandom;
        #1;
        chk("req.dmem_req", 32'(dmem_req), 32'd1);
        chk("req.dmem_addr", dmem_addr, v.e.daddr);
        chk("req.dmem_be", 32'(dmem_be), 32'(v.e.be));
        chk("req.dmem_we", 32'(dmem_we), 32'(v.i.wr));
        if (v.i.wr) chk("req.dmem_wdata", dmem_wdata, v.e.dwdata);
        chk("req.stall_out", 32'(stall_out), 32'(!rdy && !last));
        chk("req.valid_out", 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        done = rdy || last;
      end
    end
    valid_in = 1'b0; dmem_ready = 1'b0;
    if (v.e.upd) exp_rd = v.e.rd_val;
    chk("res.valid_out", 32'(valid_out), 32'd1);
    chk("res.mem_err", 32'(mem_err), 32'(v.e.mem_err));
    chk("res.wb", 32'(wb), 32'(v.e.wb));
    chk("res.alu_result", alu_result, v.i.addr);
    chk("res.write_dest", 32'(write_dest), 32'(v.i.dest));
    chk("res.read_data", read_data, exp_rd);
    $display("txn %0d: rd=%0b wr=%0b size=%0d addr=%h waits=%0d -> read_data=%h mem_err=%0b wb=%b",
             id, v.i.rd, v.i.wr, v.i.size, v.i.addr, v.i.waits, read_data, mem_err, wb);
  endtask

  vec_t tbl[14];
  vec_t rv;

  initial begin
    tbl[0].i  = mk_in(0, 0, 2'd2, 0, 32'h1234, 0, 5, 2'b01, 0, 0);
    tbl[0].e  = mk_exp(0, 0, 0, 0, 0, 0, 0, 2'b01);
    tbl[1].i  = mk_in(1, 0, 2'd0, 0, 32'h103, 0, 7, 2'b11, 2, 32'h80FFFF7F);
    tbl[1].e  = mk_exp(1, 0, 32'h100, 4'b1000, 0, 1, 32'hFFFFFF80, 2'b11);
    tbl[2].i  = mk_in(0, 1, 2'd1, 0, 32'h102, 32'h0000ABCD, 0, 2'b00, 1, 0);
    tbl[2].e  = mk_exp(1, 0, 32'h100, 4'b1100, 32'hABCDABCD, 1, 0, 2'b00);
    tbl[3].i  = mk_in(1, 0, 2'd2, 0, 32'h101, 0, 9, 2'b11, 0, 0);
    tbl[3].e  = mk_exp(0, 1, 0, 0, 0, 0, 0, 2'b00);
    tbl[4].i  = mk_in(1, 0, 2'd2, 0, 32'h200, 0, 10, 2'b11, 5, 32'h11111111);
    tbl[4].e  = mk_exp(1, 1, 32'h200, 4'b1111, 0, 0, 0, 2'b00);
    tbl[5].i  = mk_in(1, 0, 2'd1, 1, 32'h2, 0, 11, 2'b11, 0, 32'h80011234);
    tbl[5].e  = mk_exp(1, 0, 32'h0, 4'b1100, 0, 1, 32'h00008001, 2'b11);
    tbl[6].i  = mk_in(1, 0, 2'd1, 0, 32'h0, 0, 12, 2'b11, 1, 32'h1234F00D);
    tbl[6].e  = mk_exp(1, 0, 32'h0, 4'b0011, 0, 1, 32'hFFFFF00D, 2'b11);
    tbl[7].i  = mk_in(0, 1, 2'd0, 0, 32'h11, 32'h1234565A, 0, 2'b00, 0, 0);
    tbl[7].e  = mk_exp(1, 0, 32'h10, 4'b0010, 32'h5A5A5A5A, 1, 0, 2'b00);
    tbl[8].i  = mk_in(1, 1, 2'd2, 0, 32'h20, 0, 13, 2'b01, 0, 0);
    tbl[8].e  = mk_exp(0, 1, 0, 0, 0, 0, 0, 2'b00);
    tbl[9].i  = mk_in(1, 0, 2'd3, 0, 32'h30, 0, 14, 2'b11, 0, 0);
    tbl[9].e  = mk_exp(0, 1, 0, 0, 0, 0, 0, 2'b00);
    tbl[10].i = mk_in(1, 0, 2'd1, 0, 32'h3, 0, 15, 2'b11, 0, 0);
    tbl[10].e = mk_exp(0, 1, 0, 0, 0, 0, 0, 2'b00);
    tbl[11].i = mk_in(1, 0, 2'd0, 1, 32'h1, 0, 16, 2'b11, 1, 32'h00009100);
    tbl[11].e = mk_exp(1, 0, 32'h0, 4'b0010, 0, 1, 32'h00000091, 2'b11);
    tbl[12].i = mk_in(0, 1, 2'd2, 0, 32'h40, 32'hDEADBEEF, 0, 2'b00, 0, 0);
    tbl[12].e = mk_exp(1, 0, 32'h40, 4'b1111, 32'hDEADBEEF, 1, 0, 2'b00);
    tbl[13].i = mk_in(1, 0, 2'd2, 0, 32'h80, 0, 17, 2'b11, 2, 32'hCAFEF00D);
    tbl[13].e = mk_exp(1, 0, 32'h80, 4'b1111, 0, 1, 32'hCAFEF00D, 2'b11);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid_out", 32'(valid_out), 32'd0);
    chk("rst.dmem_req", 32'(dmem_req), 32'd0);
    chk("rst.stall_out", 32'(stall_out), 32'd0);
    chk("rst.read_data", read_data, 32'd0);
    chk("rst.wb", 32'(wb), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 14; n++) run_instr(tbl[n], n);
    idle_check("pulse");

    // Reset while an access is outstanding
    valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; size_in = 2'd2;
    alu_result_in = 32'h44; write_dest_in = 5'd3; wb_in = 2'b11; dmem_ready = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    #1 chk("midrst.req_before", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.dmem_req", 32'(dmem_req), 32'd0);
    chk("midrst.dmem_addr", dmem_addr, 32'd0);
    chk("midrst.alu_result", alu_result, 32'd0);
    chk("midrst.read_data", read_data, 32'd0);
    exp_rd = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    idle_check("midrst.after");
    dmem_ready = 1'b0;
    run_instr(tbl[0], 100);

    // Randomized instructions against the reference model
    for (int n = 0; n < 150; n++) begin
      int unsigned s;
      s = $urandom % 8;
      rv.i.rd    = (s >= 2 && s <= 4) || s == 7;
      rv.i.wr    = (s >= 5);
      rv.i.size  = 2'($urandom % 4);
      rv.i.uns   = 1'($urandom % 2);
      rv.i.addr  = $urandom;
      rv.i.wdata = $urandom;
      rv.i.dest  = 5'($urandom);
      rv.i.wb    = 2'($urandom);
      rv.i.waits = 8'($urandom_range(0, 4));
      rv.i.rdata = $urandom;
      rv.e = model(rv.i);
      run_instr(rv, 200 + n);
      if ($urandom % 4 == 0) idle_check("rand.idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
